// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialization sequencer: waits for PLL lock, holds the
// power-up delay, then issues PRECHARGE ALL, N_REFRESH AUTO REFRESH and
// LOAD MODE with fixed spacing before raising a sticky init_done.
// Every output is a flop whose next value is derived from the current state,
// so each command appears on the cycle after its state is entered.
// T_RP, T_RC and T_MRD are expected to be at least 2.
module sdram_init_seq #(
   parameter int unsigned T_POWERUP  = 10000,
   parameter int unsigned T_RP       = 2,
   parameter int unsigned T_RC       = 7,
   parameter int unsigned T_MRD      = 2,
   parameter int unsigned N_REFRESH  = 8,
   parameter logic [12:0] MODE_VALUE = 13'h032
) (
   input  logic        clk_50M,
   input  logic        rst_n,
   input  logic        pll_lock,
   output logic [3:0]  init_cmd,
   output logic [1:0]  init_ba,
   output logic [12:0] init_addr,
   output logic        cke,
   output logic        init_done
);

   localparam int unsigned MAX_A    = (T_POWERUP > T_RC) ? T_POWERUP : T_RC;
   localparam int unsigned MAX_B    = (T_RP > T_MRD) ? T_RP : T_MRD;
   localparam int unsigned MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
   localparam int unsigned REF_W    = $clog2(N_REFRESH + 1);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_LMR = 4'b0000;

   typedef enum logic [3:0] {
      WAIT_LOCK = 4'd0,
      POWERUP   = 4'd1,
      PRECHARGE = 4'd2,
      WAIT_RP   = 4'd3,
      REFRESH   = 4'd4,
      WAIT_RC   = 4'd5,
      LOAD_MODE = 4'd6,
      WAIT_MRD  = 4'd7,
      DONE      = 4'd8
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [REF_W-1:0]   ref_q, ref_d;
   logic [3:0]         cmd_q, cmd_d;
   logic [1:0]         ba_q, ba_d;
   logic [12:0]        addr_q, addr_d;
   logic               cke_q, cke_d;
   logic               done_q, done_d;

   // Next-state, wait counters and next output values from the current state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ref_d   = ref_q;
      cmd_d   = CMD_NOP;
      ba_d    = 2'b00;
      addr_d  = 13'h0000;
      cke_d   = 1'b1;
      done_d  = 1'b0;

      case (state_q)
         WAIT_LOCK: begin
            cke_d = 1'b0;
            if (pll_lock) begin
               state_d = POWERUP;
               cnt_d   = CNT_W'(T_POWERUP);
               ref_d   = '0;
            end
         end
         POWERUP: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = PRECHARGE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         PRECHARGE: begin
            cmd_d   = CMD_PRE;
            addr_d  = 13'h0400;
            state_d = WAIT_RP;
            cnt_d   = CNT_W'(T_RP - 1);
         end
         WAIT_RP: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = REFRESH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         REFRESH: begin
            cmd_d   = CMD_REF;
            ref_d   = ref_q + REF_W'(1);
            state_d = WAIT_RC;
            cnt_d   = CNT_W'(T_RC - 1);
         end
         WAIT_RC: begin
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = (ref_q == REF_W'(N_REFRESH)) ? LOAD_MODE : REFRESH;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         LOAD_MODE: begin
            cmd_d   = CMD_LMR;
            addr_d  = MODE_VALUE;
            state_d = WAIT_MRD;
            cnt_d   = CNT_W'(T_MRD - 1);
         end
         WAIT_MRD: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            done_d = 1'b1;
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            ref_d   = '0;
            cke_d   = 1'b0;
         end
      endcase

      // Lock loss mid-sequence aborts at once: no command, cke low, restart
      if (!pll_lock && (state_q != WAIT_LOCK) && (state_q != DONE)) begin
         state_d = WAIT_LOCK;
         cnt_d   = '0;
         ref_d   = '0;
         cmd_d   = CMD_NOP;
         ba_d    = 2'b00;
         addr_d  = 13'h0000;
         cke_d   = 1'b0;
      end
   end

   // State, counters and registered outputs with synchronous active-low reset
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         ref_q   <= '0;
         cmd_q   <= CMD_NOP;
         ba_q    <= 2'b00;
         addr_q  <= 13'h0000;
         cke_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ref_q   <= ref_d;
         cmd_q   <= cmd_d;
         ba_q    <= ba_d;
         addr_q  <= addr_d;
         cke_q   <= cke_d;
         done_q  <= done_d;
      end
   end

   assign init_cmd  = cmd_q;
   assign init_ba   = ba_q;
   assign init_addr = addr_q;
   assign cke       = cke_q;
   assign init_done = done_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: directed scenarios plus randomized lock/reset
// activity, compared every cycle against a schedule computed from the
// command timing rules, with a protocol monitor on the command stream.
module tb_sdram_init_seq;

   localparam int unsigned T_PU  = 20;
   localparam int unsigned T_RP  = 2;
   localparam int unsigned T_RC  = 7;
   localparam int unsigned T_MRD = 2;
   localparam int unsigned N_REF = 8;
   localparam logic [12:0] MODE  = 13'h032;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_LMR = 4'b0000;

   // Output cycle offsets relative to the edge where lock is first sampled
   localparam int P_J  = T_PU + 1;
   localparam int R0_J = P_J + T_RP;
   localparam int LM_J = R0_J + N_REF * T_RC;
   localparam int D_J  = LM_J + T_MRD;

   logic        clk_50M = 1'b0;
   logic        rst_n;
   logic        pll_lock;
   logic [3:0]  init_cmd;
   logic [1:0]  init_ba;
   logic [12:0] init_addr;
   logic        cke;
   logic        init_done;

   int          n_checks;
   int          n_fail;
   int          edge_n;
   int          start;
   int          ref_seen;
   logic [3:0]  prev_cmd;

   logic        e_cke;
   logic [3:0]  e_cmd;
   logic [12:0] e_addr;
   logic [1:0]  e_ba;
   logic        e_done;

   sdram_init_seq #(
      .T_POWERUP (T_PU),
      .T_RP      (T_RP),
      .T_RC      (T_RC),
      .T_MRD     (T_MRD),
      .N_REFRESH (N_REF),
      .MODE_VALUE(MODE)
   ) dut (
      .clk_50M  (clk_50M),
      .rst_n    (rst_n),
      .pll_lock (pll_lock),
      .init_cmd (init_cmd),
      .init_ba  (init_ba),
      .init_addr(init_addr),
      .cke      (cke),
      .init_done(init_done)
   );

   always #10 clk_50M = ~clk_50M;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, obs, exp, edge_n);
      end
   endtask

   // Expected outputs j cycles after lock was sampled, from the timing rules
   function automatic void sched(input int j, output logic ck, output logic [3:0] c,
                                 output logic [12:0] a, output logic dn);
      ck = (j >= 1);
      c  = C_NOP;
      a  = 13'h0000;
      dn = (j >= D_J);
      if (j == P_J) begin
         c = C_PRE;
         a = 13'h0400;
      end else if (j >= R0_J && j < LM_J && ((j - R0_J) % T_RC) == 0) begin
         c = C_REF;
      end else if (j == LM_J) begin
         c = C_LMR;
         a = MODE;
      end
   endfunction

   task automatic idle_exp();
      e_cke  = 1'b0;
      e_cmd  = C_NOP;
      e_addr = 13'h0000;
      e_ba   = 2'b00;
      e_done = 1'b0;
   endtask

   // One clock: drive inputs, advance the model, compare, run protocol checks
   task automatic step(input logic r, input logic l);
      int j;
      @(negedge clk_50M);
      rst_n    = r;
      pll_lock = l;
      @(posedge clk_50M);
      e_ba = 2'b00;
      if (!r) begin
         start = -1;
         idle_exp();
      end else if (start < 0) begin
         if (l) start = edge_n;
         idle_exp();
      end else begin
         j = edge_n - start;
         if (j < D_J && !l) begin
            start = -1;
            idle_exp();
         end else begin
            sched(j, e_cke, e_cmd, e_addr, e_done);
         end
      end
      #1;
      chk_eq("cke",  32'(cke),       32'(e_cke));
      chk_eq("cmd",  32'(init_cmd),  32'(e_cmd));
      chk_eq("addr", 32'(init_addr), 32'(e_addr));
      chk_eq("ba",   32'(init_ba),   32'(e_ba));
      chk_eq("done", 32'(init_done), 32'(e_done));
      if (init_cmd != C_NOP) begin
         chk_eq("b2b_cmd", 32'(prev_cmd != C_NOP), 32'd0);
         if (init_cmd == C_PRE) begin
            chk_eq("pre_a10", 32'(init_addr[10]), 32'd1);
            chk_eq("pre_time", 32'(edge_n - start), 32'(P_J));
            ref_seen = 0;
         end else if (init_cmd == C_REF) begin
            ref_seen++;
         end else if (init_cmd == C_LMR) begin
            chk_eq("ref_count", 32'(ref_seen), 32'(N_REF));
         end
      end
      prev_cmd = init_cmd;
      edge_n++;
   endtask

   initial begin
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      n_checks = 0;
      n_fail   = 0;
      edge_n   = 0;
      start    = -1;
      ref_seen = 0;
      prev_cmd = C_NOP;
      idle_exp();

      // Nominal run, lock from cycle 5
      repeat (3) step(1'b0, 1'b0);
      while (edge_n < 5) step(1'b1, 1'b0);
      repeat (D_J + 5) step(1'b1, 1'b1);
      chk_eq("nom_done", 32'(init_done), 32'd1);

      // Lock loss in DONE is ignored
      repeat (6) step(1'b1, 1'b0);
      chk_eq("done_sticky", 32'(init_done), 32'd1);
      chk_eq("done_nop", 32'(init_cmd), 32'(C_NOP));

      // Lock loss during the wait after the third AUTO REFRESH
      step(1'b0, 1'b1);
      repeat (R0_J + 2 * T_RC + 4) step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      chk_eq("loss_cke", 32'(cke), 32'd0);
      chk_eq("loss_nop", 32'(init_cmd), 32'(C_NOP));
      repeat (2) step(1'b1, 1'b0);
      repeat (D_J + 3) step(1'b1, 1'b1);
      chk_eq("relock_done", 32'(init_done), 32'd1);

      // Reset pulse in the middle of the power-up wait
      step(1'b0, 1'b1);
      repeat (11) step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      chk_eq("rst_cke", 32'(cke), 32'd0);
      chk_eq("rst_done", 32'(init_done), 32'd0);
      repeat (T_PU) step(1'b1, 1'b1);
      chk_eq("pu_cke", 32'(cke), 32'd1);
      chk_eq("pu_nop", 32'(init_cmd), 32'(C_NOP));
      repeat (D_J) step(1'b1, 1'b1);
      chk_eq("rst_rerun_done", 32'(init_done), 32'd1);

      // Randomized lock dropouts and occasional resets
      for (int r = 0; r < 8; r++) begin
         step(1'b0, 1'b0);
         repeat (150) step(($urandom_range(0, 299) != 0), ($urandom_range(0, 199) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
